// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC handshake, single-outstanding imem request,
// small decode FIFO, redirect flush with in-flight response squash.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] currentInstruction,
    output logic [31:0] nextInstruction,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {SYNC, REQ, WAIT, HOLD} state_t;

    state_t        state, state_n;
    logic          squash, squash_n;
    logic [31:0]   req_pc;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          push, pop, grant;
    logic [31:0]   target;

    assign grant  = (state == REQ) && imem_gnt;
    assign pop    = instr_valid && instr_ready;
    assign target = redirect_target & ~32'h3;

    always_comb begin
        state_n  = state;
        squash_n = squash;
        push     = 1'b0;
        unique case (state)
            SYNC: if (currentInstruction == nextInstruction) state_n = REQ;
            REQ:  if (imem_gnt) state_n = WAIT;
            WAIT: if (imem_rvalid) begin
                push     = !squash;
                squash_n = 1'b0;
                if (push && !pop && count == (AW+1)'(DEPTH - 1))
                    state_n = HOLD;
                else
                    state_n = SYNC;
            end
            HOLD: if (pop) state_n = SYNC;
        endcase
        // A response landing with the redirect retires the only outstanding request
        if (redirect) begin
            push = 1'b0;
            if ((state == WAIT && !imem_rvalid) || grant) begin
                squash_n = 1'b1;
                state_n  = WAIT;
            end else begin
                squash_n = 1'b0;
                state_n  = SYNC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= SYNC;
            squash          <= 1'b0;
            nextInstruction <= RESET_VECTOR;
            req_pc          <= '0;
            wptr            <= '0;
            rptr            <= '0;
            count           <= '0;
        end else begin
            state  <= state_n;
            squash <= squash_n;
            if (grant) req_pc <= currentInstruction;
            if (redirect)
                nextInstruction <= target;
            else if (grant)
                nextInstruction <= currentInstruction + 32'd4;
            if (redirect) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_data[wptr] <= imem_rdata;
            fifo_pc[wptr]   <= req_pc;
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = imem_req ? currentInstruction : '0;
    assign instr_valid = (count != '0);
    assign instr_data  = instr_valid ? fifo_data[rptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rptr] : '0;

endmodule
